// File: rtl/bitwise_logic_pkg.sv
// rtl/bitwise_logic_pkg.sv - shared op encoding for the bitwise logic unit
package bitwise_logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_ANDN  = 3'b100,
    OP_ORN   = 3'b101,
    OP_PASSA = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// rtl/bitwise_logic_unit_if.sv - beat-in / result-out handshake bundle
interface bitwise_logic_unit_if
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             acc_en;
  logic             acc_first;
  logic             acc_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             result_ones;
  logic             result_illegal;

  modport master (
    output in_valid, op, data_operandA, data_operandB, acc_en, acc_first, acc_last, out_ready,
    input  in_ready, out_valid, result, result_zero, result_ones, result_illegal
  );

  modport slave (
    input  in_valid, op, data_operandA, data_operandB, acc_en, acc_first, acc_last, out_ready,
    output in_ready, out_valid, result, result_zero, result_ones, result_illegal
  );

endinterface

// File: rtl/bitwise_op_core.sv
// rtl/bitwise_op_core.sv - combinational bitwise operation selector
module bitwise_op_core
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);

  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~(a | b);
      OP_ANDN:  y = a & ~b;
      OP_ORN:   y = a | ~b;
      OP_PASSA: y = a;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - two-stage pipelined bitwise unit with burst accumulate
module bitwise_logic_unit
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                 clock,
  input logic                 reset_n,
  bitwise_logic_unit_if.slave bus
);

  logic             s1_valid;
  logic             s1_emit;
  logic             s1_illegal;
  logic [WIDTH-1:0] s1_result;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_ones;
  logic             s2_illegal;

  logic [WIDTH-1:0] acc;
  logic             sticky;

  logic             accept;
  logic             s1_advance;
  logic             s1_retire;
  logic             beat_emit;
  logic             sticky_next;
  logic [WIDTH-1:0] eff_a;
  logic [WIDTH-1:0] core_y;
  logic             core_illegal;

  assign bus.in_ready = !s1_valid || !s2_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign s1_advance   = s1_valid && s1_emit && (!s2_valid || bus.out_ready);
  // Intermediate burst beats never need stage 2, so they leave stage 1 unconditionally.
  assign s1_retire    = s1_valid && !s1_emit;
  assign beat_emit    = !bus.acc_en || bus.acc_last;
  assign eff_a        = (bus.acc_en && !bus.acc_first) ? acc : bus.data_operandA;
  assign sticky_next  = (bus.acc_first ? 1'b0 : sticky) | core_illegal;

  bitwise_op_core #(.WIDTH(WIDTH)) u_core (
    .op      (op_t'(bus.op)),
    .a       (eff_a),
    .b       (bus.data_operandB),
    .y       (core_y),
    .illegal (core_illegal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_emit    <= 1'b0;
      s1_illegal <= 1'b0;
      s1_result  <= '0;
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_zero    <= 1'b0;
      s2_ones    <= 1'b0;
      s2_illegal <= 1'b0;
      acc        <= '0;
      sticky     <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_result  <= core_y;
        s1_emit    <= beat_emit;
        s1_illegal <= bus.acc_en ? sticky_next : core_illegal;
        if (bus.acc_en) begin
          acc    <= core_y;
          sticky <= sticky_next;
        end
      end else if (s1_advance || s1_retire) begin
        s1_valid <= 1'b0;
      end

      if (s1_advance) begin
        s2_valid   <= 1'b1;
        s2_result  <= s1_result;
        s2_zero    <= (s1_result == '0);
        s2_ones    <= &s1_result;
        s2_illegal <= s1_illegal;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = s2_valid;
  assign bus.result         = s2_result;
  assign bus.result_zero    = s2_zero;
  assign bus.result_ones    = s2_ones;
  assign bus.result_illegal = s2_illegal;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - directed and model-checked bench for bitwise_logic_unit
module tb_bitwise_logic_unit;
  import bitwise_logic_pkg::*;

  typedef struct packed {
    logic [31:0] y;
    logic        ill;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   out_count = 0;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] m_acc = '0;
  logic        m_sticky = 1'b0;
  logic        hold_valid = 1'b0;
  logic [31:0] held_result;
  logic        held_ill;

  bitwise_logic_unit_if #(.WIDTH(32)) bus ();
  bitwise_logic_unit_if #(.WIDTH(1))  bus1 ();
  bitwise_logic_unit_if #(.WIDTH(64)) bus64 ();

  bitwise_logic_unit #(.WIDTH(32)) dut   (.clock(clock), .reset_n(reset_n), .bus(bus));
  bitwise_logic_unit #(.WIDTH(1))  dut1  (.clock(clock), .reset_n(reset_n), .bus(bus1));
  bitwise_logic_unit #(.WIDTH(64)) dut64 (.clock(clock), .reset_n(reset_n), .bus(bus64));

  always #5 clock = ~clock;

  // Reference: {illegal, y} straight from the op table.
  function automatic logic [64:0] ref_op(logic [2:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, a ^ b};
      3'd3: return {1'b0, ~(a | b)};
      3'd4: return {1'b0, a & ~b};
      3'd5: return {1'b0, a | ~b};
      3'd6: return {1'b0, a};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_accept();
    logic [64:0] r;
    logic [63:0] a;
    logic        ill;
    exp_t        x;
    a   = (bus.acc_en && !bus.acc_first) ? {32'd0, m_acc} : {32'd0, bus.data_operandA};
    r   = ref_op(bus.op, a, {32'd0, bus.data_operandB});
    ill = r[64];
    if (bus.acc_en) begin
      m_sticky = (bus.acc_first ? 1'b0 : m_sticky) | r[64];
      m_acc    = r[31:0];
      ill      = m_sticky;
    end
    if (!bus.acc_en || bus.acc_last) begin
      x.y   = r[31:0];
      x.ill = ill;
      exp_q.push_back(x);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      m_acc      = '0;
      m_sticky   = 1'b0;
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_result", bus.result, held_result);
        check("hold_illegal", bus.result_illegal, held_ill);
      end
      hold_valid = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          out_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h, no result expected", bus.result);
          end else begin
            e = exp_q.pop_front();
            check("model_result", bus.result, e.y);
            check("model_zero", bus.result_zero, e.y == 32'd0);
            check("model_ones", bus.result_ones, e.y == 32'hFFFF_FFFF);
            check("model_illegal", bus.result_illegal, e.ill);
          end
        end else begin
          hold_valid  = 1'b1;
          held_result = bus.result;
          held_ill    = bus.result_illegal;
        end
      end
      if (bus.in_valid && bus.in_ready) model_accept();
    end
  end

  task automatic send(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic en, logic first, logic last);
    bit ok;
    ok = 0;
    bus.op = op;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.acc_en = en;
    bus.acc_first = first;
    bus.acc_last = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(string name, logic [31:0] y, logic z, logic o, logic ill);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.out_valid) break;
    end
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_result"}, bus.result, y);
    check({name, "_zero"}, bus.result_zero, z);
    check({name, "_ones"}, bus.result_ones, o);
    check({name, "_illegal"}, bus.result_illegal, ill);
    @(posedge clock);
    #1;
  endtask

  logic [63:0] pat_a[4] = '{64'h0, 64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] pat_b[4] = '{64'h0, 64'h0F0F_0F0F_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};

  initial begin
    int c0;
    int idx;
    bit hit;
    logic [64:0] r1;
    logic [64:0] r64;

    {bus.in_valid, bus.op, bus.data_operandA, bus.data_operandB} = '0;
    {bus.acc_en, bus.acc_first, bus.acc_last, bus.out_ready} = '0;
    {bus1.in_valid, bus1.op, bus1.data_operandA, bus1.data_operandB} = '0;
    {bus1.acc_en, bus1.acc_first, bus1.acc_last} = '0;
    bus1.out_ready = 1'b1;
    {bus64.in_valid, bus64.op, bus64.data_operandA, bus64.data_operandB} = '0;
    {bus64.acc_en, bus64.acc_first, bus64.acc_last} = '0;
    bus64.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.result_zero, 0);
    check("rst_ones", bus.result_ones, 0);
    check("rst_illegal", bus.result_illegal, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;

    // OR with latency pinned edge by edge
    send(3'd1, 32'h0000_F0F0, 32'h0F0F_0000, 0, 0, 0);
    @(negedge clock);
    check("or_early_valid", bus.out_valid, 0);
    @(negedge clock);
    check("or_valid", bus.out_valid, 1);
    check("or_result", bus.result, 32'h0F0F_F0F0);
    check("or_zero", bus.result_zero, 0);
    check("or_ones", bus.result_ones, 0);
    @(posedge clock);
    #1;

    send(3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
    expect_out("xor", 32'h0, 1, 0, 0);
    send(3'd3, 32'h0, 32'h0, 0, 0, 0);
    expect_out("nor", 32'hFFFF_FFFF, 0, 1, 0);
    send(3'd7, 32'h1234, 32'h5678, 0, 0, 0);
    expect_out("rsvd", 32'h0, 1, 0, 1);
    send(3'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 0, 0);
    expect_out("andn", 32'hF000_F000, 0, 0, 0);
    send(3'd5, 32'h0, 32'hFFFF_0000, 0, 0, 0);
    expect_out("orn", 32'h0000_FFFF, 0, 0, 0);
    send(3'd6, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 0);
    expect_out("passa", 32'h1234_5678, 0, 0, 0);

    // Three-beat OR burst folds to a single output
    c0 = out_count;
    send(3'd1, 32'h1, 32'h0, 1, 1, 0);
    send(3'd1, 32'hFFFF_FFFF, 32'h2, 1, 0, 0);
    send(3'd1, 32'hFFFF_FFFF, 32'h4, 1, 0, 1);
    expect_out("burst", 32'h7, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    check("burst_out_count", out_count - c0, 1);

    // Sticky illegal across a burst, cleared by the next first beat
    send(3'd7, 32'h0, 32'h0, 1, 1, 0);
    send(3'd1, 32'h0, 32'h1, 1, 0, 0);
    send(3'd1, 32'h0, 32'h8, 1, 0, 1);
    expect_out("sticky", 32'h9, 0, 0, 1);
    send(3'd1, 32'h3, 32'h0, 1, 1, 1);
    expect_out("sticky_clear", 32'h3, 0, 0, 0);

    // Backpressure: two beats fit, then in_ready drops
    c0 = out_count;
    bus.out_ready = 1'b0;
    idx = 0;
    bus.op = 3'd1;
    bus.acc_en = 1'b0;
    bus.data_operandA = 32'h111;
    bus.data_operandB = 32'h1000;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      hit = bus.in_ready;
      @(posedge clock);
      #1;
      if (hit) begin
        idx++;
        bus.data_operandA = 32'h111 * (idx + 1);
      end
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", idx, 2);
    @(negedge clock);
    check("bp_in_ready", bus.in_ready, 0);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("bp_drained", out_count - c0, 2);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset mid-burst clears acc
    send(3'd1, 32'h1, 32'h0, 1, 1, 0);
    send(3'd1, 32'h0, 32'h2, 1, 0, 0);
    send(3'd1, 32'h0, 32'h4, 1, 0, 0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid_out_valid", bus.out_valid, 0);
    @(posedge clock);
    #1;
    send(3'd1, 32'hFFFF_FFFF, 32'h0, 1, 0, 1);
    expect_out("acc_cleared", 32'h0, 1, 0, 0);
    send(3'd6, 32'h5, 32'h0, 1, 1, 1);
    expect_out("passa_burst", 32'h5, 0, 0, 0);

    // Random traffic against the model
    repeat (400) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op = 3'($urandom_range(0, 7));
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      bus.acc_en = ($urandom_range(0, 2) == 0);
      bus.acc_first = 1'($urandom_range(0, 1));
      bus.acc_last = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("random_queue_empty", exp_q.size(), 0);

    // WIDTH=1 exhaustive and WIDTH=64 patterned sweep over every op
    for (int op = 0; op < 8; op++) begin
      for (int p = 0; p < 4; p++) begin
        bus1.op = 3'(op);
        bus1.data_operandA = 1'(p >> 1);
        bus1.data_operandB = 1'(p);
        bus64.op = 3'(op);
        bus64.data_operandA = pat_a[p];
        bus64.data_operandB = pat_b[p];
        bus1.in_valid = 1'b1;
        bus64.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus1.in_valid = 1'b0;
        bus64.in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        r1  = ref_op(3'(op), {63'd0, 1'(p >> 1)}, {63'd0, 1'(p)});
        r64 = ref_op(3'(op), pat_a[p], pat_b[p]);
        check("w1_valid", bus1.out_valid, 1);
        check("w1_result", bus1.result, r1[0]);
        check("w1_zero", bus1.result_zero, !r1[0]);
        check("w1_illegal", bus1.result_illegal, r1[64]);
        check("w64_valid", bus64.out_valid, 1);
        check("w64_result", bus64.result, r64[63:0]);
        check("w64_ones", bus64.result_ones, &r64[63:0]);
        check("w64_illegal", bus64.result_illegal, r64[64]);
        @(posedge clock);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
